// File: rtl/fft_pkg.sv
// ------------------------------------------------------------------
// fft_pkg: shared types, select codes and width helpers for the FFT
// controller.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fft_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_RD_E      = 4'd2,
        ST_RD_O      = 4'd3,
        ST_CAP       = 4'd4,
        ST_WR_T      = 4'd5,
        ST_WR_B      = 4'd6,
        ST_UNLD_RD   = 4'd7,
        ST_UNLD_WAIT = 4'd8
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_TOP  = 2'b01;
    localparam logic [1:0] SEL_BOT  = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Stage counter width; never narrower than one bit.
    function automatic int stage_w(input int l);
        return (clog2(l) < 1) ? 1 : clog2(l);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_controller_if.sv
// ------------------------------------------------------------------
// fft_controller_if: start, load and unload handshakes of the FFT
// controller.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface fft_controller_if;
    logic i_start;
    logic i_in_valid;
    logic o_in_ready;
    logic o_out_valid;
    logic i_out_ready;
    logic o_busy;
    logic o_done;

    modport master (
        output i_start, i_in_valid, i_out_ready,
        input  o_in_ready, o_out_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_in_valid, i_out_ready,
        output o_in_ready, o_out_valid, o_busy, o_done
    );
endinterface

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// ------------------------------------------------------------------
// fft_addr_gen: even/odd RAM and twiddle ROM addresses for butterfly b
// of stage s.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int L  = 3,
    parameter int SW = stage_w(L)
) (
    input  logic [SW-1:0] s_i,
    input  logic [L-2:0]  b_i,
    output logic [L-1:0]  even_o,
    output logic [L-1:0]  odd_o,
    output logic [L-1:0]  tw_o
);

    logic [L-1:0]  b_ext;
    logic [L-1:0]  half;
    logic [L-1:0]  pos;
    logic [L-1:0]  grp;
    logic [L-1:0]  even;
    logic [SW-1:0] tw_shift;

    always_comb begin
        b_ext    = {1'b0, b_i};
        half     = L'(1) << s_i;
        pos      = b_ext & (half - L'(1));
        grp      = b_ext >> s_i;
        // pos < half, so bit s of even is always clear and odd is a plain OR
        even     = ((grp << s_i) << 1) | pos;
        tw_shift = SW'(L - 1) - s_i;
        even_o   = even;
        odd_o    = even | half;
        tw_o     = pos << tw_shift;
    end

endmodule

`default_nettype wire

// File: rtl/fft_controller.sv
// ------------------------------------------------------------------
// fft_controller: load / butterfly / unload sequencer for the ping-pong
// radix-2 DIT FFT memory and datapath.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fft_controller
    import fft_pkg::*;
#(
    parameter int   N  = 8,
    localparam int  L  = clog2(N),
    localparam int  SW = stage_w(L)
) (
    input  logic         clk,
    input  logic         rst,
    fft_controller_if.slave bus,
    output logic         o_RAM1_wr_en,
    output logic         o_RAM2_wr_en,
    output logic         o_RAM1_rd_en,
    output logic         o_RAM2_rd_en,
    output logic         o_ROM_rd_en,
    output logic [L-1:0] o_RAM1_wr_addr,
    output logic [L-1:0] o_RAM2_wr_addr,
    output logic [L-1:0] o_RAM1_rd_addr,
    output logic [L-1:0] o_RAM2_rd_addr,
    output logic [L-1:0] o_ROM_rd_addr,
    output logic [1:0]   o_ctrl_RAM1_data,
    output logic [1:0]   o_ctrl_RAM2_data,
    output logic         o_ctrl_data,
    output logic         o_ctrl_even_odd,
    output logic         o_even_vld,
    output logic         o_odd_vld
);

    localparam logic [L-1:0]  CNT_LAST = L'(N - 1);
    localparam logic [L-2:0]  B_LAST   = (L - 1)'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(L - 1);
    // Each stage swaps RAMs, so an odd stage count leaves results in RAM2.
    localparam logic          RES_RAM2 = (L % 2 == 1);

    state_t        state_q, state_d;
    logic [L-1:0]  cnt_q, cnt_d;
    logic [SW-1:0] s_q, s_d;
    logic [L-2:0]  b_q, b_d;
    logic          done_q, done_d;

    logic [L-1:0]  cnt_rev;
    logic [L-1:0]  even_addr;
    logic [L-1:0]  odd_addr;
    logic [L-1:0]  tw_addr;
    logic          src_ram2;
    logic          in_ready;
    logic          out_valid;

    fft_addr_gen #(
        .L  (L),
        .SW (SW)
    ) u_addr_gen (
        .s_i    (s_q),
        .b_i    (b_q),
        .even_o (even_addr),
        .odd_o  (odd_addr),
        .tw_o   (tw_addr)
    );

    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < L; i++) cnt_rev[i] = cnt_q[L-1-i];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        b_d     = b_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (bus.i_in_valid) begin
                    cnt_d = cnt_q + L'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RD_E;
                        s_d     = '0;
                        b_d     = '0;
                    end
                end
            end
            ST_RD_E: state_d = ST_RD_O;
            ST_RD_O: state_d = ST_CAP;
            ST_CAP:  state_d = ST_WR_T;
            ST_WR_T: state_d = ST_WR_B;
            ST_WR_B: begin
                state_d = ST_RD_E;
                if (b_q == B_LAST) begin
                    b_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = ST_UNLD_RD;
                        s_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    b_d = b_q + (L - 1)'(1);
                end
            end
            ST_UNLD_RD: state_d = ST_UNLD_WAIT;
            ST_UNLD_WAIT: begin
                if (bus.i_out_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_UNLD_RD;
                        cnt_d   = cnt_q + L'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    assign src_ram2 = s_q[0];

    always_comb begin
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        o_RAM1_wr_en     = 1'b0;
        o_RAM2_wr_en     = 1'b0;
        o_RAM1_rd_en     = 1'b0;
        o_RAM2_rd_en     = 1'b0;
        o_ROM_rd_en      = 1'b0;
        o_RAM1_wr_addr   = '0;
        o_RAM2_wr_addr   = '0;
        o_RAM1_rd_addr   = '0;
        o_RAM2_rd_addr   = '0;
        o_ROM_rd_addr    = '0;
        o_ctrl_RAM1_data = SEL_LOAD;
        o_ctrl_RAM2_data = SEL_LOAD;
        o_ctrl_data      = 1'b0;
        o_ctrl_even_odd  = 1'b0;
        o_even_vld       = 1'b0;
        o_odd_vld        = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready         = 1'b1;
                o_RAM1_wr_en     = bus.i_in_valid;
                o_RAM1_wr_addr   = cnt_rev;
                o_ctrl_RAM1_data = SEL_LOAD;
            end
            ST_RD_E: begin
                o_ctrl_data = src_ram2;
                if (src_ram2) begin
                    o_RAM2_rd_en   = 1'b1;
                    o_RAM2_rd_addr = even_addr;
                end else begin
                    o_RAM1_rd_en   = 1'b1;
                    o_RAM1_rd_addr = even_addr;
                end
            end
            ST_RD_O: begin
                o_ctrl_data   = src_ram2;
                o_even_vld    = 1'b1;
                o_ROM_rd_en   = 1'b1;
                o_ROM_rd_addr = tw_addr;
                if (src_ram2) begin
                    o_RAM2_rd_en   = 1'b1;
                    o_RAM2_rd_addr = odd_addr;
                end else begin
                    o_RAM1_rd_en   = 1'b1;
                    o_RAM1_rd_addr = odd_addr;
                end
            end
            ST_CAP: begin
                o_ctrl_data     = src_ram2;
                o_ctrl_even_odd = 1'b1;
                o_odd_vld       = 1'b1;
            end
            ST_WR_T, ST_WR_B: begin
                o_ctrl_data = src_ram2;
                if (src_ram2) begin
                    o_RAM1_wr_en     = 1'b1;
                    o_RAM1_wr_addr   = (state_q == ST_WR_T) ? even_addr : odd_addr;
                    o_ctrl_RAM1_data = (state_q == ST_WR_T) ? SEL_TOP : SEL_BOT;
                end else begin
                    o_RAM2_wr_en     = 1'b1;
                    o_RAM2_wr_addr   = (state_q == ST_WR_T) ? even_addr : odd_addr;
                    o_ctrl_RAM2_data = (state_q == ST_WR_T) ? SEL_TOP : SEL_BOT;
                end
            end
            ST_UNLD_RD, ST_UNLD_WAIT: begin
                // Address and RAM select are held through the wait so the
                // presented result cannot change before it is accepted.
                o_ctrl_data = RES_RAM2;
                out_valid   = (state_q == ST_UNLD_WAIT);
                if (RES_RAM2) begin
                    o_RAM2_rd_en   = (state_q == ST_UNLD_RD);
                    o_RAM2_rd_addr = cnt_q;
                end else begin
                    o_RAM1_rd_en   = (state_q == ST_UNLD_RD);
                    o_RAM1_rd_addr = cnt_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = out_valid;
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_controller.sv
// ------------------------------------------------------------------
// tb_fft_controller: directed bench for the N=8 FFT controller.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fft_controller;

    localparam int N = 8;
    localparam int L = 3;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       busy;
        logic       done;
        logic       r1we;
        logic       r2we;
        logic       r1re;
        logic       r2re;
        logic       romre;
        logic [2:0] r1wa;
        logic [2:0] r2wa;
        logic [2:0] r1ra;
        logic [2:0] r2ra;
        logic [2:0] roma;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       ctrl_data;
        logic       even_odd;
        logic       even_vld;
        logic       odd_vld;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_controller_if bus();

    logic         r1we, r2we, r1re, r2re, romre;
    logic [L-1:0] r1wa, r2wa, r1ra, r2ra, roma;
    logic [1:0]   sel1, sel2;
    logic         ctrl_data, even_odd, even_vld, odd_vld;

    fft_controller #(.N(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .o_RAM1_wr_en     (r1we),
        .o_RAM2_wr_en     (r2we),
        .o_RAM1_rd_en     (r1re),
        .o_RAM2_rd_en     (r2re),
        .o_ROM_rd_en      (romre),
        .o_RAM1_wr_addr   (r1wa),
        .o_RAM2_wr_addr   (r2wa),
        .o_RAM1_rd_addr   (r1ra),
        .o_RAM2_rd_addr   (r2ra),
        .o_ROM_rd_addr    (roma),
        .o_ctrl_RAM1_data (sel1),
        .o_ctrl_RAM2_data (sel2),
        .o_ctrl_data      (ctrl_data),
        .o_ctrl_even_odd  (even_odd),
        .o_even_vld       (even_vld),
        .o_odd_vld        (odd_vld)
    );

    logic [1:0]   ag_s;
    logic [1:0]   ag_b;
    logic [L-1:0] ag_even, ag_odd, ag_tw;

    fft_addr_gen #(.L(L), .SW(2)) u_ag (
        .s_i    (ag_s),
        .b_i    (ag_b),
        .even_o (ag_even),
        .odd_o  (ag_odd),
        .tw_o   (ag_tw)
    );

    // Hand-derived N=8 butterfly schedule, index = 4*s + b.
    logic [2:0] ev_tab [0:11] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] od_tab [0:11] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] tw_tab [0:11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] brev_tab [0:7] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    int checks = 0;
    int passes = 0;

    function automatic snap_t obs();
        snap_t o;
        o.in_ready  = bus.o_in_ready;
        o.out_valid = bus.o_out_valid;
        o.busy      = bus.o_busy;
        o.done      = bus.o_done;
        o.r1we      = r1we;
        o.r2we      = r2we;
        o.r1re      = r1re;
        o.r2re      = r2re;
        o.romre     = romre;
        o.r1wa      = r1wa;
        o.r2wa      = r2wa;
        o.r1ra      = r1ra;
        o.r2ra      = r2ra;
        o.roma      = roma;
        o.sel1      = sel1;
        o.sel2      = sel2;
        o.ctrl_data = ctrl_data;
        o.even_odd  = even_odd;
        o.even_vld  = even_vld;
        o.odd_vld   = odd_vld;
        return o;
    endfunction

    // Addresses only matter while their enable is high.
    function automatic snap_t mk_mask(input snap_t e);
        snap_t m;
        m = '1;
        if (!e.r1we)  m.r1wa = '0;
        if (!e.r2we)  m.r2wa = '0;
        if (!e.r1re)  m.r1ra = '0;
        if (!e.r2re)  m.r2ra = '0;
        if (!e.romre) m.roma = '0;
        return m;
    endfunction

    task automatic test_reset();
        snap_t e, o;
        repeat (2) @(negedge clk);
        #1;
        e = '0;
        o = obs();
        checks++;
        if (o !== e) $display("FAIL reset_outputs: got %h expected %h", o, e);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        o = obs();
        checks++;
        if (o !== e) $display("FAIL idle_no_start: got %h expected %h", o, e);
        else passes++;
    endtask

    task automatic test_addr_gen();
        for (int i = 0; i < 12; i++) begin
            ag_s = 2'(i / 4);
            ag_b = 2'(i % 4);
            #1;
            checks++;
            if ({ag_even, ag_odd, ag_tw} !== {ev_tab[i], od_tab[i], tw_tab[i]})
                $display("FAIL addr_gen s%0d b%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         i / 4, i % 4, ag_even, ag_odd, ag_tw, ev_tab[i], od_tab[i], tw_tab[i]);
            else passes++;
        end
    endtask

    task automatic test_load();
        snap_t e, o, m;
        int k, c;
        logic v;
        @(negedge clk);
        bus.i_start = 1'b1;
        #1;
        e = '0;
        o = obs();
        checks++;
        if (o !== e) $display("FAIL load_pre_start: got %h expected %h", o, e);
        else passes++;
        @(negedge clk);
        bus.i_start = 1'b0;
        k = 0;
        c = 0;
        while (k < N) begin
            v = !(c == 1 || c == 4 || c == 5);
            bus.i_in_valid = v;
            #1;
            e = '0;
            e.in_ready = 1'b1;
            e.busy     = 1'b1;
            e.r1we     = v;
            e.r1wa     = brev_tab[k];
            o = obs();
            m = mk_mask(e);
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL load cyc%0d: got %h expected %h", c, o & m, e & m);
            else passes++;
            @(negedge clk);
            if (v) k++;
            c++;
        end
        bus.i_in_valid = 1'b0;
    endtask

    task automatic test_compute(input bit pulse_start);
        snap_t e, o, m;
        logic src;
        for (int i = 0; i < 12; i++) begin
            for (int ph = 0; ph < 5; ph++) begin
                src = ((i / 4) % 2 == 1);
                bus.i_start = (pulse_start && i == 5 && ph == 2);
                #1;
                e = '0;
                e.busy      = 1'b1;
                e.ctrl_data = src;
                case (ph)
                    0: if (src) begin e.r2re = 1'b1; e.r2ra = ev_tab[i]; end
                       else     begin e.r1re = 1'b1; e.r1ra = ev_tab[i]; end
                    1: begin
                        if (src) begin e.r2re = 1'b1; e.r2ra = od_tab[i]; end
                        else     begin e.r1re = 1'b1; e.r1ra = od_tab[i]; end
                        e.romre    = 1'b1;
                        e.roma     = tw_tab[i];
                        e.even_vld = 1'b1;
                    end
                    2: begin e.even_odd = 1'b1; e.odd_vld = 1'b1; end
                    3: if (src) begin e.r1we = 1'b1; e.r1wa = ev_tab[i]; e.sel1 = 2'b01; end
                       else     begin e.r2we = 1'b1; e.r2wa = ev_tab[i]; e.sel2 = 2'b01; end
                    default: if (src) begin e.r1we = 1'b1; e.r1wa = od_tab[i]; e.sel1 = 2'b10; end
                             else     begin e.r2we = 1'b1; e.r2wa = od_tab[i]; e.sel2 = 2'b10; end
                endcase
                o = obs();
                m = mk_mask(e);
                checks++;
                if ((o & m) !== (e & m))
                    $display("FAIL compute s%0d b%0d ph%0d: got %h expected %h", i / 4, i % 4, ph, o & m, e & m);
                else passes++;
                @(negedge clk);
            end
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_unload(input int stall_k);
        snap_t e, o, m;
        int waits;
        for (int k = 0; k < N; k++) begin
            bus.i_out_ready = 1'b0;
            #1;
            e = '0;
            e.busy      = 1'b1;
            e.r2re      = 1'b1;
            e.r2ra      = 3'(k);
            e.ctrl_data = 1'b1;
            o = obs();
            m = mk_mask(e);
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL unload_rd[%0d]: got %h expected %h", k, o & m, e & m);
            else passes++;
            @(negedge clk);
            waits = (k == stall_k) ? 3 : 0;
            for (int w = 0; w <= waits; w++) begin
                bus.i_out_ready = (w == waits);
                #1;
                e = '0;
                e.busy      = 1'b1;
                e.out_valid = 1'b1;
                e.r2ra      = 3'(k);
                o = obs();
                m = mk_mask(e);
                m.r2ra      = '1;
                m.ctrl_data = 1'b0;
                checks++;
                if ((o & m) !== (e & m)) $display("FAIL unload_wait[%0d.%0d]: got %h expected %h", k, w, o & m, e & m);
                else passes++;
                @(negedge clk);
            end
        end
        bus.i_out_ready = 1'b0;
        #1;
        e = '0;
        e.done = 1'b1;
        o = obs();
        checks++;
        if (o !== e) $display("FAIL done_pulse: got %h expected %h", o, e);
        else passes++;
        @(negedge clk);
        #1;
        e = '0;
        o = obs();
        checks++;
        if (o !== e) $display("FAIL done_single: got %h expected %h", o, e);
        else passes++;
    endtask

    task automatic test_reset_midrun();
        snap_t e, o, m;
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_in_valid = 1'b1;
        repeat (N) @(negedge clk);
        bus.i_in_valid = 1'b0;
        repeat (21) @(negedge clk);
        #1;
        e = '0;
        e.busy      = 1'b1;
        e.ctrl_data = 1'b1;
        e.r2re      = 1'b1;
        e.r2ra      = 3'd2;
        e.romre     = 1'b1;
        e.roma      = 3'd0;
        e.even_vld  = 1'b1;
        o = obs();
        m = mk_mask(e);
        checks++;
        if ((o & m) !== (e & m)) $display("FAIL stage1_rd_o: got %h expected %h", o & m, e & m);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        e = '0;
        o = obs();
        checks++;
        if (o !== e) $display("FAIL async_reset: got %h expected %h", o, e);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_in_valid = 1'b1;
        #1;
        e = '0;
        e.in_ready = 1'b1;
        e.busy     = 1'b1;
        e.r1we     = 1'b1;
        e.r1wa     = 3'd0;
        o = obs();
        m = mk_mask(e);
        checks++;
        if ((o & m) !== (e & m)) $display("FAIL reentry_cnt0: got %h expected %h", o & m, e & m);
        else passes++;
        @(negedge clk);
        #1;
        e.r1wa = 3'd4;
        o = obs();
        checks++;
        if ((o & m) !== (e & m)) $display("FAIL reentry_cnt1: got %h expected %h", o & m, e & m);
        else passes++;
        @(negedge clk);
        bus.i_in_valid = 1'b0;
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b0;
        ag_s = '0;
        ag_b = '0;
        test_reset();
        test_addr_gen();
        test_load();
        test_compute(1'b1);
        test_unload(2);
        test_reset_midrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_controller.md
# fft_controller

Sequencing controller for the radix-2 DIT FFT memory/datapath (ping-pong RAM1/RAM2 re/im pairs plus the twiddle ROM). It performs three jobs:
- loads N input samples in bit-reversed order through a valid/ready handshake;
- runs log2(N) butterfly stages, alternating source and destination RAM each stage;
- streams the N results out through a second handshake.

It sits between the top-level streaming ports and the memory block, and drives all memory enables, addresses and mux/demux selects.

## Interface
- N, 8, FFT size; power of two, ≥4. L = log2(N) is the address width.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_in_valid  in  1  input sample present on the memory load-data ports
- o_in_ready  out  1  controller accepts a sample this cycle
- o_out_valid  out  1  result on the memory even outputs is valid
- i_out_ready  in  1  consumer accepts the result
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the last result is accepted
- o_RAM1_wr_en, o_RAM2_wr_en  out  1  write enables; top level fans each out to the re and im enables
- o_RAM1_rd_en, o_RAM2_rd_en, o_ROM_rd_en  out  1  read enables
- o_RAM1_wr_addr, o_RAM2_wr_addr, o_RAM1_rd_addr, o_RAM2_rd_addr, o_ROM_rd_addr  out  L  addresses
- o_ctrl_RAM1_data, o_ctrl_RAM2_data  out  2  write-data select: 00 load, 01 top, 10 bottom
- o_ctrl_data  out  1  read RAM select: 0 RAM1, 1 RAM2
- o_ctrl_even_odd  out  1  demux select: 0 even, 1 odd
- o_even_vld, o_odd_vld  out  1  capture strobes for the butterfly input registers

## Operation
- States:
  - IDLE
  - LOAD
  - RD_E
  - RD_O
  - CAP
  - WR_T
  - WR_B
  - UNLD_RD
  - UNLD_WAIT
- Counters: cnt (L bits) for load/unload, stage s (0..L-1), butterfly b (0..N/2-1).
- IDLE: on i_start, go to LOAD with cnt=0. While busy, i_start is ignored.
- LOAD: o_in_ready=1.
  - On i_in_valid, o_RAM1_wr_en=1 (combinational from i_in_valid), o_RAM1_wr_addr=bitrev(cnt), o_ctrl_RAM1_data=00.
  - cnt increments on each handshake. The handshake with cnt=N-1 goes to RD_E with s=0, b=0.
- Butterfly address math:
  - half = 1<<s; pos = b & (half-1); grp = b>>s
  - even = grp·2·half + pos; odd = even + half
  - twiddle address tw = pos << (L-1-s)
- Ping-pong: the source RAM is RAM1 when s is even, RAM2 when s is odd. The destination is the other RAM. o_ctrl_data = s[0].
- Butterfly slot, 5 cycles:
  - RD_E: source rd_en, rd_addr=even.
  - RD_O: o_ctrl_even_odd=0, o_even_vld=1; source rd_en, rd_addr=odd; ROM rd_en, addr=tw.
  - CAP: o_ctrl_even_odd=1, o_odd_vld=1.
  - WR_T: destination wr_en, addr=even, data select 01.
  - WR_B: destination wr_en, addr=odd, data select 10. Then advance b. When b wraps, advance s. When s=L-1 and b=N/2-1, go to UNLD_RD with cnt=0.
- Unload: the result RAM is RAM2 if L is odd, RAM1 if L is even.
  - UNLD_RD: rd_en, rd_addr=cnt, o_ctrl_data=result RAM, o_ctrl_even_odd=0.
  - UNLD_WAIT: o_out_valid=1 with no rd_en, so the RAM output holds. On i_out_ready: if cnt=N-1, pulse o_done and go to IDLE; otherwise cnt+1 and go to UNLD_RD.
- Enables not listed for a state are 0. Selects not listed are 0.

## Timing
- Reset value of every output is 0. State resets to IDLE and all counters to 0.
- Reset asserted mid-operation aborts immediately. RAM contents are untouched. The next i_start restarts from LOAD.
- Memory read latency is 1 cycle: data addressed in cycle k is on the outputs in cycle k+1.
- Butterfly result (top/bot) is valid the cycle after o_odd_vld.
- Compute phase is 5·L·N/2 cycles (N=8: 60).
- Unload: ≥2 cycles per sample. o_out_valid and its data stay stable until i_out_ready is seen.
- Apart from the LOAD write path, all outputs are decoded from registered state and counters only.

## Structure
- Package fft_pkg holds:
  - state enum;
  - clog2 function;
  - mux-select constants SEL_LOAD=00, SEL_TOP=01, SEL_BOT=10.
- Sub-module fft_addr_gen: combinational; takes (s, b) and produces (even, odd, tw). Reused by the testbench model.

## Test plan
- N=8 load of samples 0..7 → RAM1 write addresses 0,4,2,6,1,5,3,7 with select 00, one per handshake; gaps in i_in_valid insert no writes.
- Stage 1, b=1 → read RAM2 at 1 then 3; ROM addr 2; write RAM1 at 1 (select 01) and then 3 (select 10).
- Full run N=8 → last LOAD handshake to first UNLD_RD is 60 cycles; results are read from RAM2 at addresses 0..7; o_done pulses once.
- Unload with i_out_ready held low for 3 cycles → o_out_valid stays high and o_RAM2_rd_addr is unchanged; no new rd_en.
- Reset during stage 1 → all outputs 0 the same cycle; i_start re-entry gives o_in_ready=1 with cnt=0.
- i_start pulsed during compute → ignored; sequence and cycle count are unchanged.
